// File: rtl/key_pkg.sv
// Shared types and default timing for the key event decoder.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } key_state_e;

  // 1 s long-press and 200 ms auto-repeat at a 50 MHz clock
  localparam int unsigned KEY_LONG_CYCLES_DEF   = 50_000_000;
  localparam int unsigned KEY_REPEAT_CYCLES_DEF = 10_000_000;

  function automatic logic key_is_held(input key_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/key_event_if.sv
// Key level in, decoded key events out.
interface key_event_if;

  logic       i_key_in;
  logic       o_press;
  logic       o_release;
  logic       o_click;
  logic       o_long;
  logic       o_rpt;
  logic       o_held;
  logic [7:0] o_press_count;

  modport master (
    output i_key_in,
    input  o_press, o_release, o_click, o_long, o_rpt, o_held, o_press_count
  );

  modport slave (
    input  i_key_in,
    output o_press, o_release, o_click, o_long, o_rpt, o_held, o_press_count
  );

endinterface

// File: rtl/key_event.sv
// Turns a debounced active-low key level into press/release/click/long/repeat
// pulses, a held level and a wrapping press counter. All outputs registered.
module key_event
  import key_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = KEY_LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = KEY_REPEAT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  key_event_if.slave  bus
);

  localparam logic [31:0] LONG_LAST   = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CYCLES - 1);

  key_state_e  r_state;
  logic        r_key_q;
  logic [31:0] r_cnt;
  logic [7:0]  r_press_count;
  logic        r_press;
  logic        r_release;
  logic        r_click;
  logic        r_long;
  logic        r_rpt;
  logic        r_held;

  key_state_e  w_state_n;
  logic [31:0] w_cnt_n;
  logic [7:0]  w_press_count_n;
  logic        w_press_evt;
  logic        w_release_evt;
  logic        w_press;
  logic        w_release;
  logic        w_click;
  logic        w_long;
  logic        w_rpt;

  assign w_press_evt   =  r_key_q & ~bus.i_key_in;
  assign w_release_evt = ~r_key_q &  bus.i_key_in;

  // Release is tested before the threshold match so it wins a same-cycle tie.
  always_comb begin
    w_state_n       = r_state;
    w_cnt_n         = '0;
    w_press_count_n = r_press_count;
    w_press         = 1'b0;
    w_release       = 1'b0;
    w_click         = 1'b0;
    w_long          = 1'b0;
    w_rpt           = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_press_evt) begin
          w_state_n       = ST_PRESSED;
          w_press         = 1'b1;
          w_press_count_n = r_press_count + 8'd1;
        end
      end
      ST_PRESSED: begin
        if (w_release_evt) begin
          w_state_n = ST_IDLE;
          w_release = 1'b1;
          w_click   = 1'b1;
        end else if (r_cnt == LONG_LAST) begin
          w_state_n = ST_LONG;
          w_long    = 1'b1;
        end else begin
          w_cnt_n = r_cnt + 32'd1;
        end
      end
      ST_LONG: begin
        if (w_release_evt) begin
          w_state_n = ST_IDLE;
          w_release = 1'b1;
        end else if (r_cnt == REPEAT_LAST) begin
          w_rpt = 1'b1;
        end else begin
          w_cnt_n = r_cnt + 32'd1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_key_q       <= 1'b1;
      r_cnt         <= '0;
      r_press_count <= '0;
      r_press       <= 1'b0;
      r_release     <= 1'b0;
      r_click       <= 1'b0;
      r_long        <= 1'b0;
      r_rpt         <= 1'b0;
      r_held        <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_key_q       <= bus.i_key_in;
      r_cnt         <= w_cnt_n;
      r_press_count <= w_press_count_n;
      r_press       <= w_press;
      r_release     <= w_release;
      r_click       <= w_click;
      r_long        <= w_long;
      r_rpt         <= w_rpt;
      r_held        <= key_is_held(w_state_n);
    end
  end

  assign bus.o_press       = r_press;
  assign bus.o_release     = r_release;
  assign bus.o_click       = r_click;
  assign bus.o_long        = r_long;
  assign bus.o_rpt         = r_rpt;
  assign bus.o_held        = r_held;
  assign bus.o_press_count = r_press_count;

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter LONG_CYCLES, default 50_000_000: hold time for a long press, in clk cycles (1 s at 50 MHz); legal range 2..2^31-1.
REQ-002 Parameter REPEAT_CYCLES, default 10_000_000: auto-repeat period after a long press, in clk cycles (200 ms); legal range 2..2^31-1.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 key_in  input  1  debounced key level, active-low (1 = released, 0 = pressed).
REQ-006 press  output  1  one-cycle pulse on a press.
REQ-007 release  output  1  one-cycle pulse on a release.
REQ-008 click  output  1  one-cycle pulse on a release that comes before the long threshold.
REQ-009 long  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
REQ-010 rpt  output  1  one-cycle auto-repeat pulse while a long hold continues.
REQ-011 held  output  1  level; 1 while the FSM is in PRESSED or LONG.
REQ-012 press_count  output  8  total presses since reset; wraps 255 -> 0.

Function
REQ-013 key_in SHALL be registered into key_q; a press is key_q=1 with key_in=0, and a release is key_q=0 with key_in=1.
REQ-014 All outputs SHALL be registered, so every pulse is high in the cycle after the sampled edge (latency 1).
REQ-015 The FSM SHALL have three states:
- IDLE
- PRESSED
- LONG
REQ-016 IDLE + press: go to PRESSED, assert press, clear hold counter, increment press_count.
REQ-017 PRESSED: the hold counter SHALL increment every cycle; when it reaches LONG_CYCLES-1 with no release, go to LONG, assert long, clear the counter. The long pulse therefore falls exactly LONG_CYCLES cycles after the press pulse.
REQ-018 LONG: the counter SHALL increment every cycle; at REPEAT_CYCLES-1, assert rpt and clear the counter. Repeats fall at LONG_CYCLES + k*REPEAT_CYCLES after press, k >= 1.
REQ-019 PRESSED + release: assert release and click in the same cycle, go to IDLE.
REQ-020 LONG + release: assert release only (no click), go to IDLE.
REQ-021 A release in the same cycle as a threshold match SHALL win: no long or rpt pulse, and the state goes to IDLE.
REQ-022 The hold counter SHALL be 32 bits, unsigned, compared for equality only, and cleared on every state change.
REQ-023 At most one of press, long and rpt SHALL be high in any cycle; release and click are the only outputs allowed to coincide.
REQ-024 held SHALL be a registered decode of the next state, so it rises with press and falls with release.
REQ-025 press_count SHALL increment by exactly 1 per press and wrap modulo 256 with no flag.

Reset
REQ-026 While rst=1, the block SHALL be in IDLE with key_q=1, counter=0, press_count=0 and all pulse outputs and held at 0, in the cycle after rst is sampled.
REQ-027 rst asserted mid-hold SHALL abort the hold with no release or click pulse.
REQ-028 If key_in=0 when rst deasserts, the block SHALL treat it as a press: press is asserted 1 cycle after the first non-reset cycle and press_count becomes 1.
REQ-029 rst SHALL take priority over all key events.

Structure
REQ-030 The state encoding type and the default LONG_CYCLES/REPEAT_CYCLES values SHALL live in a shared package key_pkg; the module's parameter defaults come from it.
REQ-031 key_event SHALL be a single flat module with no sub-modules; in the system it sits directly after the debouncer output.

Verification (bench overrides LONG_CYCLES=20, REPEAT_CYCLES=5; press pulse cycle = P)
REQ-032 Drive key_in low for 10 cycles, then high -> press at P, then release and click together at P+10; long=0 and rpt=0 throughout; press_count=1.
REQ-033 Hold key_in low for 40 cycles -> long at P+20; rpt at P+25, P+30, P+35; then release without click; held=1 from P to the release pulse.
REQ-034 Release timed to the cycle in which the counter equals 19 -> release and click asserted, long never asserted.
REQ-035 Assert rst at P+8 during a hold -> all outputs 0 the next cycle, no release pulse, press_count=0; with key_in still low at rst deassertion, press 1 cycle later and press_count=1.
REQ-036 Apply 257 short presses (3 cycles low, 3 cycles high) -> 257 press pulses and press_count=1 after wrap.
REQ-037 Randomised key_in with runs of at least 2 cycles -> scoreboard checks REQ-023 every cycle and that press and release pulses alternate starting with press.
